fir_transposed_param: RTL and testbench

Parametrised transposed-form FIR filter with a run-time loadable, double-buffered coefficient bank, rounded/scaled output and a one-cycle output-valid strobe. It sits in the sample-rate datapath, clocked by the 12 MHz system clock and advanced by the 300 kHz sample enable. It replaces fixed-tap, fixed-width multiply/add/shift chains with a single configurable block.

---
 rtl/fir_transposed_param.sv | 173 +++++++++++++++++
 tb/tb_fir_transposed_param.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_transposed_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fir_transposed_param                                           |
// | Purpose : Transposed-form FIR filter with a double-buffered, run-time    |
// |           loadable coefficient bank, round-half-up scaling and a         |
// |           one-cycle output-valid strobe.                                 |
// | Ports   : iClk_12M       system clock (posedge)                          |
// |           iRsn           asynchronous active-low reset                   |
// |           iEnSample_300k sample strobe, one cycle wide                   |
// |           iFirIn         signed input sample                             |
// |           iCoeffWrEn     shadow-bank write enable                        |
// |           iCoeffAddr     shadow-bank tap index                           |
// |           iCoeffData     signed coefficient                              |
// |           iCoeffCommit   request shadow -> active swap                   |
// |           oFirOut        registered signed output                        |
// |           oValid         one-cycle pulse, oFirOut updated                |
// |           oBusy          commit pending, shadow writes ignored           |
// |           oSat           one-cycle pulse with oValid when clipped        |
// | Config  : define FIR_SAT_EN to clamp the output to the OUT_W range and   |
// |           report it on oSat; otherwise the output wraps and oSat = 0.    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module fir_transposed_param #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iEnSample_300k,
  input  logic [DATA_W-1:0] iFirIn,
  input  logic              iCoeffWrEn,
  input  logic [AW-1:0]     iCoeffAddr,
  input  logic [COEF_W-1:0] iCoeffData,
  input  logic              iCoeffCommit,
  output logic [OUT_W-1:0]  oFirOut,
  output logic              oValid,
  output logic              oBusy,
  output logic              oSat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + AW;
  // One guard bit so the rounding offset can never overflow the accumulator.
  localparam int RND_W  = ACC_W + 1;
  localparam logic [RND_W-1:0] RND_OFS =
    (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [COEF_W-1:0] shadow_q [TAPS];
  logic [COEF_W-1:0] active_q [TAPS];
  logic [ACC_W-1:0]  r_q      [1:TAPS-1];
  logic [ACC_W-1:0]  r_d      [1:TAPS-1];
  logic [ACC_W-1:0]  prod_ext [TAPS];

  logic [OUT_W-1:0]  fir_out_q, fir_out_d;
  logic              valid_q, sat_q, sat_d;
  logic              pend;
  logic              wr_ok;

  logic [ACC_W-1:0]        y_sum;
  logic [RND_W-1:0]        y_rnd;
  logic signed [RND_W-1:0] y_sh;

  // While a commit is pending, the next strobe already computes with the
  // shadow bank and an empty delay line, so the swap costs no extra sample.
  assign pend  = (state_q == ST_PEND);
  assign wr_ok = iCoeffWrEn && !pend && ({1'b0, iCoeffAddr} < (AW+1)'(TAPS));

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [COEF_W-1:0]        coef;
    logic signed [PROD_W-1:0] prod;
    assign coef = pend ? shadow_q[k] : active_q[k];
    assign prod = $signed({{COEF_W{iFirIn[DATA_W-1]}}, iFirIn}) *
                  $signed({{DATA_W{coef[COEF_W-1]}}, coef});
    assign prod_ext[k] = {{AW{prod[PROD_W-1]}}, prod};
  end

  for (genvar k = 1; k < TAPS; k++) begin : g_chain
    if (k == TAPS - 1) begin : g_last
      assign r_d[k] = prod_ext[k];
    end else begin : g_mid
      assign r_d[k] = prod_ext[k] + (pend ? '0 : r_q[k+1]);
    end
  end

  assign y_sum = prod_ext[0] + (pend ? '0 : r_q[1]);
  assign y_rnd = {y_sum[ACC_W-1], y_sum} + RND_OFS;
  assign y_sh  = $signed(y_rnd) >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [RND_W-1:0] SAT_HI =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    fir_out_d = y_sh[OUT_W-1:0];
    sat_d     = 1'b0;
    if (y_sh > SAT_HI) begin
      fir_out_d = {1'b0, {(OUT_W-1){1'b1}}};
      sat_d     = 1'b1;
    end else if (y_sh < SAT_LO) begin
      fir_out_d = {1'b1, {(OUT_W-1){1'b0}}};
      sat_d     = 1'b1;
    end
  end
`else
  // Two's-complement wrap: the bits above OUT_W are intentionally dropped.
  logic unused_sh_hi;
  assign fir_out_d    = y_sh[OUT_W-1:0];
  assign sat_d        = 1'b0;
  assign unused_sh_hi = ^y_sh[RND_W-1:OUT_W];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (iCoeffCommit)   state_d = ST_PEND;
      ST_PEND: if (iEnSample_300k) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= ST_RUN;
      fir_out_q <= '0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      for (int k = 1; k < TAPS; k++) begin
        r_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= iEnSample_300k;
      sat_q   <= iEnSample_300k & sat_d;
      if (wr_ok) begin
        shadow_q[iCoeffAddr] <= iCoeffData;
      end
      if (iEnSample_300k) begin
        fir_out_q <= fir_out_d;
        for (int k = 1; k < TAPS; k++) begin
          r_q[k] <= r_d[k];
        end
        if (pend) begin
          for (int k = 0; k < TAPS; k++) begin
            active_q[k] <= shadow_q[k];
          end
        end
      end
    end
  end

  assign oFirOut = fir_out_q;
  assign oValid  = valid_q;
  assign oBusy   = pend;
  assign oSat    = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_transposed_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fir_transposed_param                                        |
// | Purpose : Scoreboard bench for fir_transposed_param. Unit 0 uses the     |
// |           default parameters, unit 1 uses TAPS=4, SHIFT=0. A direct-form |
// |           reference model predicts every output; a monitor compares.     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_fir_transposed_param;

  logic        clk;
  logic        rst_n;
  logic        stb_a, stb_b, we_a, we_b, cmt_a, cmt_b;
  logic [15:0] fir_in, cdata;
  logic [3:0]  addr_a;
  logic [1:0]  addr_b;
  logic [15:0] out_a, out_b;
  logic        valid_a, valid_b, busy_a, busy_b, sat_a, sat_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] out;
    logic        sat;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state: coefficient banks, recent inputs (newest first).
  shortint m_shd [2][64];
  shortint m_act [2][64];
  shortint m_hist[2][64];
  bit      m_pend[2];

  fir_transposed_param u_dut_a (
    .iClk_12M(clk), .iRsn(rst_n), .iEnSample_300k(stb_a), .iFirIn(fir_in),
    .iCoeffWrEn(we_a), .iCoeffAddr(addr_a), .iCoeffData(cdata),
    .iCoeffCommit(cmt_a), .oFirOut(out_a), .oValid(valid_a),
    .oBusy(busy_a), .oSat(sat_a)
  );

  fir_transposed_param #(.TAPS(4), .SHIFT(0)) u_dut_b (
    .iClk_12M(clk), .iRsn(rst_n), .iEnSample_300k(stb_b), .iFirIn(fir_in),
    .iCoeffWrEn(we_b), .iCoeffAddr(addr_b), .iCoeffData(cdata),
    .iCoeffCommit(cmt_b), .oFirOut(out_b), .oValid(valid_b),
    .oBusy(busy_b), .oSat(sat_b)
  );

  initial begin
    clk = 1'b0;
    forever #42 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pend[u] = 1'b0;
      for (int k = 0; k < 64; k++) begin
        m_shd[u][k]  = 0;
        m_act[u][k]  = 0;
        m_hist[u][k] = 0;
      end
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock cycle of stimulus for unit u (other unit idle) plus the model.
  task automatic step(input int u, input bit stb, input logic [15:0] x, input bit we,
                      input int addr, input logic [15:0] data, input bit cmt);
    int      n, sh, a;
    bit      po;
    longint  acc, r;
    exp_t    e;
    logic [31:0] av;
    check("busy_a", {31'b0, busy_a}, {31'b0, m_pend[0]});
    check("busy_b", {31'b0, busy_b}, {31'b0, m_pend[1]});
    av     = addr;
    stb_a  = stb && (u == 0);
    stb_b  = stb && (u == 1);
    we_a   = we && (u == 0);
    we_b   = we && (u == 1);
    cmt_a  = cmt && (u == 0);
    cmt_b  = cmt && (u == 1);
    addr_a = av[3:0];
    addr_b = av[1:0];
    fir_in = x;
    cdata  = data;

    n  = (u == 0) ? 10 : 4;
    sh = (u == 0) ? 15 : 0;
    a  = (u == 0) ? (addr & 15) : (addr & 3);
    po = m_pend[u];
    if (stb) begin
      if (po) begin
        for (int k = 0; k < n; k++) begin
          m_act[u][k]  = m_shd[u][k];
          m_hist[u][k] = 0;
        end
      end
      for (int k = n - 1; k > 0; k--) m_hist[u][k] = m_hist[u][k-1];
      m_hist[u][0] = shortint'(x);
      acc = 0;
      for (int k = 0; k < n; k++) acc += longint'(m_hist[u][k]) * longint'(m_act[u][k]);
      r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
`ifdef FIR_SAT_EN
      if (r > 32767) begin
        e.out = 16'h7FFF; e.sat = 1'b1;
      end else if (r < -32768) begin
        e.out = 16'h8000; e.sat = 1'b1;
      end else begin
        e.out = r[15:0]; e.sat = 1'b0;
      end
`else
      e.out = r[15:0];
      e.sat = 1'b0;
`endif
      e.due = cyc + 1;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    if (we && !po && a < n) m_shd[u][a] = shortint'(data);
    if (cmt && !po) m_pend[u] = 1'b1;
    if (stb && po)  m_pend[u] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      step(0, 1'b0, 16'h0, 1'b0, 0, 16'h0, 1'b0);
    end
  endtask

  task automatic strobe(input int u, input logic [15:0] x);
    @(negedge clk);
    step(u, 1'b1, x, 1'b0, 0, 16'h0, 1'b0);
    idle(1);
  endtask

  task automatic wr(input int u, input int a, input logic [15:0] d);
    @(negedge clk);
    step(u, 1'b0, 16'h0, 1'b1, a, d, 1'b0);
  endtask

  task automatic commit(input int u);
    @(negedge clk);
    step(u, 1'b0, 16'h0, 1'b0, 0, 16'h0, 1'b1);
  endtask

  // Monitor: every oValid must match the oldest prediction, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_a) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL valid_a_unexpected: got oValid=1, expected no output (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          check("lat_a", cyc, e.due);
          check("out_a", {16'b0, out_a}, {16'b0, e.out});
          check("sat_a", {31'b0, sat_a}, {31'b0, e.sat});
        end
      end else if (sat_a) begin
        n_checks++; n_fail++;
        $display("FAIL sat_a_alone: got oSat=1 without oValid, expected 0 (cycle %0d)", cyc);
      end
      if (valid_b) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL valid_b_unexpected: got oValid=1, expected no output (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          check("lat_b", cyc, e.due);
          check("out_b", {16'b0, out_b}, {16'b0, e.out});
          check("sat_b", {31'b0, sat_b}, {31'b0, e.sat});
        end
      end
    end
  end

  initial begin
    {stb_a, stb_b, we_a, we_b, cmt_a, cmt_b} = '0;
    fir_in = '0; cdata = '0; addr_a = '0; addr_b = '0;
    rst_n = 1'b1;
    model_reset();
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_a",   {16'b0, out_a}, 32'h0);
    check("rst_valid_a", {31'b0, valid_a}, 32'h0);
    check("rst_busy_a",  {31'b0, busy_a}, 32'h0);
    check("rst_sat_a",   {31'b0, sat_a}, 32'h0);
    check("rst_out_b",   {16'b0, out_b}, 32'h0);
    check("rst_valid_b", {31'b0, valid_b}, 32'h0);
    rst_n = 1'b1;

    // All-zero banks after reset.
    for (int i = 0; i < 3; i++) begin
      strobe(0, 16'($urandom));
      strobe(1, 16'($urandom));
    end

    // Impulse on the 4-tap, unscaled unit.
    for (int k = 0; k < 4; k++) wr(1, k, 16'(k + 1));
    commit(1);
    idle(1);
    strobe(1, 16'd1);
    for (int i = 0; i < 4; i++) strobe(1, 16'd0);

    // Rounding on the default unit.
    wr(0, 0, 16'h4000);
    commit(0);
    strobe(0, 16'h0003);
    strobe(0, 16'h2000);

    // Saturation / wrap with all coefficients at full scale.
    for (int k = 0; k < 10; k++) wr(0, k, 16'h7FFF);
    commit(0);
    for (int i = 0; i < 12; i++) strobe(0, 16'h7FFF);

    // Commit colliding with a strobe, and writes dropped while busy.
    strobe(1, 16'd5);
    strobe(1, 16'hFFFD);
    for (int k = 0; k < 4; k++) wr(1, k, 16'(10 + k));
    @(negedge clk);
    step(1, 1'b1, 16'd7, 1'b0, 0, 16'h0, 1'b1);
    idle(1);
    wr(1, 0, 16'h0BAD);
    wr(1, 2, 16'h0BAD);
    strobe(1, 16'd2);
    strobe(1, 16'd1);
    commit(1);
    strobe(1, 16'd1);
    for (int i = 0; i < 4; i++) strobe(1, 16'd0);

    // Out-of-range addresses on the 10-tap unit must not touch any tap.
    for (int a = 10; a < 16; a++) wr(0, a, 16'h1111);
    commit(0);
    strobe(0, 16'h0100);
    for (int i = 0; i < 10; i++) strobe(0, 16'h0000);

    // Randomised traffic; strobes only on even cycles keep them 2 apart.
    for (int i = 0; i < 400; i++) begin
      int u;
      bit s;
      u = int'($urandom_range(0, 1));
      s = ((i % 2) == 0) && ($urandom_range(0, 9) < 7);
      @(negedge clk);
      step(u, s, 16'($urandom), ($urandom_range(0, 9) < 3), int'($urandom_range(0, 15)),
           16'($urandom), ($urandom_range(0, 19) == 0));
    end
    idle(2);

    // Asynchronous reset in the middle of streaming.
    commit(1);
    @(negedge clk);
    step(0, 1'b1, 16'h7FFF, 1'b0, 0, 16'h0, 1'b0);
    @(posedge clk);
    #10;
    check("pre_rst_valid_a", {31'b0, valid_a}, 32'h1);
    check("pre_rst_busy_b",  {31'b0, busy_b}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_a",   {16'b0, out_a}, 32'h0);
    check("mid_rst_valid_a", {31'b0, valid_a}, 32'h0);
    check("mid_rst_busy_b",  {31'b0, busy_b}, 32'h0);
    check("mid_rst_sat_a",   {31'b0, sat_a}, 32'h0);
    check("mid_rst_out_b",   {16'b0, out_b}, 32'h0);
    model_reset();
    {stb_a, stb_b, we_a, we_b, cmt_a, cmt_b} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(0, 16'($urandom));
      strobe(1, 16'($urandom));
    end
    commit(0);
    strobe(0, 16'h7FFF);
    strobe(0, 16'h4000);
    idle(3);

    check("pending_a", q0.size(), 32'h0);
    check("pending_b", q1.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
